shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 28 ++
 rtl/shift_count.sv | 27 ++
 rtl/shift_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: command opcodes, FSM states,
// datapath width and the command-to-shift-count mapping.
package shift_sequencer_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ROL  = 2'b01,
    OP_ROR  = 2'b10,
    OP_ASR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of active register edges a command needs: LOAD is one, count 0 is a full 8.
  function automatic logic [CNT_W-1:0] shift_amount(input logic [1:0] op,
                                                    input logic [2:0] count);
    if (op == OP_LOAD) return CNT_W'(1);
    return (count == 3'd0) ? CNT_W'(8) : {1'b0, count};
  endfunction

endpackage

// File: rtl/shift_count.sv
// Loadable 4-bit down counter; zero flags that no further RUN edges remain.
module shift_count
  import shift_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer driving an external 8-bit load/rotate/ASR shift register
// for exactly N clock edges, then pulsing done.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       count,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             ParallelLoadn,
  output logic             RotateRight,
  output logic             ASRight,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  op_e              op_p0;
  op_e              run_op;
  logic [WIDTH-1:0] data_p0;
  logic             sign_p0;
  logic             accept;
  logic             cnt_load;
  logic             cnt_zero;
  logic             pl_nxt, rr_nxt, asr_nxt;

  assign accept = (state == ST_IDLE) && start;

  // The counter holds the RUN edges still to come after the current one.
  shift_count u_count (
    .clk   (clk),
    .rst   (Reset),
    .load  (cnt_load),
    .value (shift_amount(op, count) - CNT_W'(1)),
    .dec   (state == ST_RUN),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      ParallelLoadn <= 1'b0;
      RotateRight   <= 1'b0;
      ASRight       <= 1'b0;
    end else begin
      state         <= state_nxt;
      ParallelLoadn <= pl_nxt;
      RotateRight   <= rr_nxt;
      ASRight       <= asr_nxt;
    end
  end

  // Command capture: frozen for the whole command, so input changes in flight are harmless.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= op_e'(op);
      data_p0 <= load_data;
      sign_p0 <= Q_IN[WIDTH-1];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    run_op    = op_p0;
    pl_nxt    = 1'b0;
    rr_nxt    = 1'b0;
    asr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          cnt_load  = 1'b1;
          run_op    = op_e'(op);
        end
      end
      ST_RUN:  if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Controls are registered, so they are decoded for the state being entered.
    if (state_nxt == ST_RUN) begin
      case (run_op)
        OP_LOAD: pl_nxt = 1'b0;
        OP_ROL:  pl_nxt = 1'b1;
        OP_ROR:  begin pl_nxt = 1'b1; rr_nxt = 1'b1; end
        OP_ASR:  begin pl_nxt = 1'b1; rr_nxt = 1'b1; asr_nxt = 1'b1; end
        default: pl_nxt = 1'b0;
      endcase
    end
  end

  always_comb begin
    DATA_OUT = Q_IN;
    if (state == ST_RUN) begin
      case (op_p0)
        OP_LOAD: DATA_OUT = data_p0;
        OP_ASR:  DATA_OUT = {sign_p0, {(WIDTH-1){1'b0}}};
        default: DATA_OUT = Q_IN;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
